// File: rtl/bcd_converter.sv
// bcd_converter: sequential binary-to-BCD converter (shift-and-add-3).
// One shift per sys_clk edge; WIDTH shifts per conversion, then a LOAD
// cycle that publishes the digits, the sign flag and a leading-zero mask
// for the 7-segment digit mux.
module bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  // Leading-zero mask of an all-zero result: every digit but the ones blanked.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  // Constant helper for the range check below.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // DIGITS must be able to hold every magnitude a WIDTH-bit operand can produce.
  generate
    if (pow10(DIGITS) <= (64'd1 << WIDTH)) begin : g_range_err
      $error("bcd_converter: DIGITS too small for WIDTH (need 10**DIGITS > 2**WIDTH)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic                sign;
  logic [WIDTH-1:0]    mag;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adjusted;
  logic [DIGITS-1:0]   blank_next;
  logic [CW-1:0]       count;
  logic                accept;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    // NOTE: non-blocking assignments for every register so all flops update
    // from pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_next -> no latch.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (count == CW'(WIDTH - 1)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction: every nibble judged on its pre-adjust value, in parallel.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero mask: digit i blanks when it and every digit above it are zero.
  always_comb begin
    blank_next = '0;
    for (int i = 1; i < DIGITS; i++) begin
      blank_next[i] = ~|(scratch >> (4 * i));
    end
  end

  // Conversion datapath and result registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sign     <= 1'b0;
      mag      <= '0;
      scratch  <= '0;
      count    <= '0;
      bcd      <= '0;
      negative <= 1'b0;
      blank    <= BLANK_RST;
      done     <= 1'b0;
    end else begin
      done <= (state == LOAD);
      unique case (state)
        IDLE: begin
          if (accept) begin
            sign    <= signed_mode & value[WIDTH-1];
            // Two's-complement negate is WIDTH bits wide: the most negative
            // input maps to itself, which read unsigned is its magnitude.
            mag     <= (signed_mode & value[WIDTH-1]) ? WIDTH'(~value + 1'b1) : value;
            scratch <= '0;
            count   <= '0;
          end
        end
        SHIFT: begin
          {scratch, mag} <= {adjusted, mag} << 1;
          count          <= count + 1'b1;
        end
        LOAD: begin
          bcd      <= scratch;
          negative <= sign;
          blank    <= blank_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Testbench for bcd_converter: a driver issues conversions and pushes the
// reference result into a scoreboard queue; an independent monitor pops and
// compares whenever done pulses.
module tb_bcd_converter;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int LAT    = WIDTH + 1;

  logic                sys_clk = 1'b0;
  logic                rst     = 1'b1;
  logic                start   = 1'b0;
  logic                signed_mode = 1'b0;
  logic [WIDTH-1:0]    value   = '0;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                negative;
  logic [DIGITS-1:0]   blank;

  bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .value       (value),
    .busy        (busy),
    .done        (done),
    .bcd         (bcd),
    .negative    (negative),
    .blank       (blank)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic                neg;
    logic [DIGITS-1:0]   blank;
    int                  acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge sys_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: decimal digits by plain division of the signed/unsigned magnitude.
  function automatic exp_t model(input int v, input bit s);
    exp_t e;
    int   x, m;
    bit   neg;
    neg = s && (v >= (1 << (WIDTH - 1)));
    m   = neg ? (1 << WIDTH) - v : v;
    e.neg   = neg && (m != 0);
    e.bcd   = '0;
    e.blank = '0;
    x = m;
    for (int i = 0; i < DIGITS; i++) begin
      e.bcd[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    for (int i = 1; i < DIGITS; i++) begin
      int p = 1;
      for (int j = 0; j < i; j++) p = p * 10;
      e.blank[i] = (m < p);
    end
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compares results on done, otherwise checks the outputs hold.
  exp_t last;
  int   busy_run = 0;
  always @(negedge sys_clk) begin
    if (rst) begin
      busy_run   = 0;
      last.bcd   = '0;
      last.neg   = 1'b0;
      last.blank = 3'b110;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd",      32'(bcd),      32'(e.bcd));
        check("negative", 32'(negative), 32'(e.neg));
        check("blank",    32'(blank),    32'(e.blank));
        check("latency",  32'(cyc - e.acc), 32'(LAT));
        check("busy_len", 32'(busy_run), 32'(LAT));
        for (int i = 0; i < DIGITS; i++)
          check("nibble_range", 32'(bcd[4*i +: 4] <= 4'd9), 32'd1);
        last = e;
      end
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      check("hold_bcd",      32'(bcd),      32'(last.bcd));
      check("hold_negative", 32'(negative), 32'(last.neg));
      check("hold_blank",    32'(blank),    32'(last.blank));
    end
  end

  // Waits for idle (bounded), presents one start pulse, optionally scores it.
  task automatic convert(input logic [WIDTH-1:0] v, input bit s, input bit push);
    int   t;
    exp_t e;
    t = 0;
    while (busy && t < 100) begin
      @(posedge sys_clk); #1;
      t++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    start = 1'b1;
    value = v;
    signed_mode = s;
    @(posedge sys_clk); #1;
    start = 1'b0;
    value = WIDTH'($urandom);
    signed_mode = 1'($urandom);
    if (push) begin
      e = model(int'(v), s);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  typedef struct { logic [WIDTH-1:0] v; bit s; } stim_t;
  stim_t sweep[$];

  initial begin
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_bcd",      32'(bcd),      32'd0);
    check("rst_negative", 32'(negative), 32'd0);
    check("rst_blank",    32'(blank),    32'h6);

    // Directed values, unsigned then signed.
    convert(8'hFF, 1'b0, 1'b1);
    convert(8'h07, 1'b0, 1'b1);
    convert(8'h00, 1'b0, 1'b1);
    convert(8'h80, 1'b1, 1'b1);
    convert(8'hFF, 1'b1, 1'b1);
    convert(8'h7F, 1'b1, 1'b1);
    convert(8'h00, 1'b1, 1'b1);

    // Starts during a conversion are ignored; next start right after done.
    convert(8'h2A, 1'b0, 1'b1);
    start = 1'b1; value = 8'h63;
    @(posedge sys_clk); #1 start = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 start = 1'b1; value = 8'h63; signed_mode = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
    convert(8'h63, 1'b0, 1'b1);

    // Reset in the 4th SHIFT cycle aborts the conversion.
    convert(8'hC8, 1'b0, 1'b1);
    convert(8'h05, 1'b0, 1'b0);
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b1;
    #2;
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_done",     32'(done),     32'd0);
    check("abort_bcd",      32'(bcd),      32'd0);
    check("abort_negative", 32'(negative), 32'd0);
    check("abort_blank",    32'(blank),    32'h6);
    check("abort_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge sys_clk); #1 rst = 1'b0;
    repeat (15) @(posedge sys_clk);
    #1;
    convert(8'h05, 1'b0, 1'b1);

    // Every value in both modes, in shuffled order.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < (1 << WIDTH); i++) begin
        stim_t st;
        st.v = WIDTH'(i);
        st.s = 1'(m);
        sweep.push_back(st);
      end
    for (int i = sweep.size() - 1; i > 0; i--) begin
      int    j;
      stim_t tmp;
      j = $urandom_range(i, 0);
      tmp = sweep[i]; sweep[i] = sweep[j]; sweep[j] = tmp;
    end
    foreach (sweep[i]) convert(sweep[i].v, sweep[i].s, 1'b1);

    // Drain the scoreboard (bounded).
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge sys_clk);
    @(negedge sys_clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_converter.md
Name: bcd_converter

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one shift per clock.
- Sits between the output-register latch and the 7-segment digit mux, on the display's sys_clk domain.
- Replaces combinational divide/modulo digit extraction.
- Supports unsigned and two's-complement signed display, and provides a leading-zero blank mask for the digit mux.

Parameters:
- WIDTH, 8, bit width of the binary input.
- DIGITS, 3, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH (elaboration-time assertion).

Ports:
- sys_clk  input  1  conversion clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion of value; sampled only when busy=0.
- signed_mode  input  1  1: treat value as two's complement; 0: unsigned. Sampled with start.
- value  input  WIDTH  binary operand; sampled with start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when a new result is presented.
- bcd  output  4*DIGITS  result digits, bcd[3:0] = ones, bcd[7:4] = tens, etc.; each nibble 0-9.
- negative  output  1  result is a negative signed value.
- blank  output  DIGITS  bit i=1 means digit i is a leading zero; bit 0 is always 0.

Behaviour:
- Reset (async, rst=1):
  - FSM -> IDLE, busy=0, done=0, bcd=0, negative=0.
  - blank = all ones except bit 0 (for DIGITS=3: 3'b110).
  - Scratch registers and shift counter cleared.
  - Reset mid-conversion aborts it; the result is discarded.
- States:
  - IDLE -> SHIFT: on start=1.
  - SHIFT -> SHIFT: while count < WIDTH-1.
  - SHIFT -> LOAD: on the WIDTH-th shift.
  - LOAD -> IDLE: unconditionally.
- Accept edge (IDLE & start):
  - Latch sign = signed_mode & value[WIDTH-1].
  - Latch magnitude = sign ? (~value + 1) : value, truncated to WIDTH bits. Signed -128 (0x80) yields magnitude 0x80, i.e. 128.
  - Clear BCD scratch; count=0; busy goes high after this edge.
- Each SHIFT edge:
  - Every scratch nibble >= 5 gets +3 (all nibbles evaluated in parallel on pre-adjust values).
  - Then {scratch, magnitude} shifts left by 1.
  - count increments.
  - Exactly WIDTH shifts are performed.
- LOAD edge:
  - bcd <= scratch; negative <= sign.
  - blank[i] (i >= 1) = 1 iff scratch digits i..DIGITS-1 are all zero.
  - done=1 for exactly this cycle.
  - busy=0 after this edge.
- Latency: start accepted at edge k -> bcd/done valid after edge k+WIDTH+1 (WIDTH=8: 9 edges). busy is high for WIDTH+1 cycles.
- A new start is accepted in the cycle following done (IDLE). Back-to-back throughput is one conversion per WIDTH+2 cycles.
- start while busy=1 is ignored; there is no queueing and value/signed_mode changes have no effect.
- bcd, negative and blank hold their last result between conversions, and also during a conversion until LOAD.
- Zero result: negative=0 even if signed_mode=1 (signed 0 has no sign bit set).
- Sign and magnitude arithmetic is WIDTH bits wide; no overflow is possible because DIGITS satisfies the range constraint.

Test Plan:
- Reset, then start with value=0xFF, signed_mode=0 -> after 9 edges done pulses once, bcd=0x255, negative=0, blank=3'b000; busy high for exactly 9 cycles.
- value=0x07, signed_mode=0 -> bcd=0x007, blank=3'b110. Then value=0x00 -> bcd=0x000, blank=3'b110, negative=0.
- signed_mode=1: value=0x80 -> bcd=0x128, negative=1. value=0xFF -> bcd=0x001, negative=1, blank=3'b110. value=0x7F -> bcd=0x127, negative=0.
- Start 0x2A, then pulse start with 0x63 on cycles 2 and 5 of the conversion -> single done, bcd=0x042. Start 0x63 on the cycle after done -> bcd=0x099.
- Convert 0xC8 (bcd=0x200), start 0x05, assert rst on the 4th SHIFT cycle -> busy=0, done never pulses, bcd=0, blank=3'b110. A subsequent start of 0x05 -> bcd=0x005.
- Random sweep of all 256 values in both modes, checked against a reference model; every result arrives exactly WIDTH+1 edges after accept, and every nibble stays <= 9.
